// File: rtl/cache_line_array.sv
// cache_line_array: byte-masked line storage with per-entry valid bits and a walking flush
module cache_line_array #(
  parameter int WIDTH      = 256,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [INDEX_BITS-1:0] windex,
  input  logic [WIDTH/8-1:0]    wmask,
  input  logic [WIDTH-1:0]      datain,
  input  logic [INDEX_BITS-1:0] rindex,
  output logic [WIDTH-1:0]      dataout,
  output logic                  valid_out,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done
);
  localparam int DEPTH = 2**INDEX_BITS;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t                state;
  logic [INDEX_BITS-1:0] cnt;
  logic [DEPTH-1:0]      valid;
  logic [WIDTH-1:0]      mem [DEPTH] = '{default: '0};
  logic                  wr;
  assign flush_busy = state == FLUSH;
  assign wr = load && !flush_busy;
  assign valid_out = !flush_busy && (valid[rindex] || (load && rindex == windex));
  for (genvar i = 0; i < WIDTH/8; i++) begin : g_lane
    assign dataout[8*i +: 8] = (wr && rindex == windex && wmask[i]) ? datain[8*i +: 8] : mem[rindex][8*i +: 8];
  end
  // data storage is deliberately outside the reset domain so it survives rst_n
  always_ff @(posedge clk)
    for (int i = 0; i < WIDTH/8; i++)
      if (wr && wmask[i]) mem[windex][8*i +: 8] <= datain[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid      <= '0;
      state      <= IDLE;
      cnt        <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (state == FLUSH) begin
        valid[cnt] <= 1'b0;
        cnt        <= cnt + 1'b1;
        if (&cnt) begin
          state      <= IDLE;
          flush_done <= 1'b1;
        end
      end else begin
        if (load) valid[windex] <= 1'b1;
        if (flush_req) begin
          state <= FLUSH;
          cnt   <= '0;
        end
      end
    end
endmodule

// File: tb/tb_cache_line_array.sv
// tb_cache_line_array: randomized scoreboard bench against a behavioural line-array model
module tb_cache_line_array;
  localparam int W = 256;
  localparam int IB = 4;
  localparam int D = 16;
  localparam int L = W/8;
  logic clk = 0, rst_n = 0, load = 0, flush_req = 0;
  logic [IB-1:0] windex = 0, rindex = 0;
  logic [L-1:0] wmask = 0;
  logic [W-1:0] datain = 0, dataout;
  logic valid_out, flush_busy, flush_done;
  cache_line_array #(.WIDTH(W), .INDEX_BITS(IB)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .windex(windex), .wmask(wmask),
    .datain(datain), .rindex(rindex), .dataout(dataout), .valid_out(valid_out),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done));
  always #5 clk = ~clk;
  typedef struct packed {logic [W-1:0] d; logic v; logic b; logic f;} exp_t;
  exp_t q[$];
  logic [W-1:0] mem_m [D];
  logic [D-1:0] val_m = '0;
  int rem = 0;
  logic done_m = 0;
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  exp_t me;
  always @(negedge clk)
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("dataout", dataout, me.d);
      chk("valid_out", W'(valid_out), W'(me.v));
      chk("flush_busy", W'(flush_busy), W'(me.b));
      chk("flush_done", W'(flush_done), W'(me.f));
    end
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  // model: flush is a countdown; entries are all invalid once it ends, and reads are forced invalid meanwhile
  task automatic step(input logic r, input logic ld, input logic fr, input logic [IB-1:0] wi,
                      input logic [IB-1:0] ri, input logic [L-1:0] m, input logic [W-1:0] din);
    exp_t e;
    logic busy, wr, nd;
    rst_n = r; load = ld; flush_req = fr; windex = wi; rindex = ri; wmask = m; datain = din;
    if (!r) begin
      rem = 0; val_m = '0; done_m = 0;
    end
    busy = rem > 0;
    wr = ld && !busy;
    for (int i = 0; i < L; i++) e.d[8*i +: 8] = (wr && ri == wi && m[i]) ? din[8*i +: 8] : mem_m[ri][8*i +: 8];
    e.v = !busy && (val_m[ri] || (ld && ri == wi));
    e.b = busy;
    e.f = done_m;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      nd = 0;
      if (busy) begin
        rem--;
        if (rem == 0) begin
          val_m = '0;
          nd = 1;
        end
      end else begin
        if (ld) begin
          for (int i = 0; i < L; i++) if (m[i]) mem_m[wi][8*i +: 8] = din[8*i +: 8];
          val_m[wi] = 1'b1;
        end
        if (fr) rem = D;
      end
      done_m = nd;
    end
    #1;
  endtask
  task automatic rd(input logic [IB-1:0] ri);
    step(1, 0, 0, 0, ri, '0, '0);
  endtask
  task automatic read_all();
    for (int i = 0; i < D; i++) rd(IB'(i));
  endtask
  task automatic fill();
    for (int i = 0; i < D; i++) step(1, 1, 0, IB'(i), IB'($urandom), {L{1'b1}}, rnd());
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1);
  end
  initial begin
    logic [IB-1:0] wi;
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, '0, '0);
    read_all();
    step(1, 1, 0, 3, 3, {L{1'b1}}, rnd());
    step(1, 1, 0, 3, 0, L'(1), rnd());
    rd(3);
    step(1, 1, 0, 5, 5, L'(32'h0F), rnd());
    rd(5);
    fill();
    read_all();
    step(1, 0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 18; i++) step(1, 1, 0, IB'($urandom), IB'($urandom), L'($urandom), rnd());
    read_all();
    fill();
    step(1, 0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 7; i++) rd(IB'(i));
    step(0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 1, '0, '0);
    read_all();
    step(1, 1, 1, 2, 2, {L{1'b1}}, rnd());
    for (int i = 0; i < 18; i++) rd(2);
    read_all();
    for (int n = 0; n < 600; n++) begin
      wi = IB'($urandom);
      if ($urandom_range(199) == 0) step(0, 0, 0, 0, IB'($urandom), '0, '0);
      else step(1, $urandom_range(1) == 1, $urandom_range(29) == 0, wi,
                ($urandom_range(2) == 0) ? wi : IB'($urandom), L'($urandom), rnd());
    end
    read_all();
    @(posedge clk); #1;
    chk("queue_drained", W'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
